// File: rtl/obi_sram_responder.sv
// OBI responder backed by a word-addressed SRAM, fixed latency, in-order responses.
// Define OBI_SRAM_RESPONDER_ERR_EN to add err_o and out-of-range error responses.
module obi_sram_responder #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_WORDS       = 1024,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
`ifdef OBI_SRAM_RESPONDER_ERR_EN
    ,
    output logic                    err_o
`endif
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFF = $clog2(NB);
    localparam int IW  = $clog2(NUM_WORDS);
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
`ifdef OBI_SRAM_RESPONDER_ERR_EN
    localparam int EW  = DATA_WIDTH + 1;
`else
    localparam int EW  = DATA_WIDTH;
`endif

    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
    logic [EW-1:0]         q_mem_q [MAX_OUTSTANDING];

    logic [CW-1:0]         credits_q, credits_d;
    logic [CW-1:0]         qcnt_q, qcnt_d;
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;

    logic [IW-1:0]         idx;
    logic                  grant;
    logic                  pop;
    logic                  oor;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [EW-1:0]         in_entry;
    logic                  push;
    logic [EW-1:0]         push_entry;
    logic [EW-1:0]         head;

    assign idx = addr_i[OFF +: IW];

`ifdef OBI_SRAM_RESPONDER_ERR_EN
    assign oor = addr_i >= ADDR_WIDTH'(NUM_WORDS * NB);
`else
    assign oor = 1'b0;
    logic unused_hi;
    assign unused_hi = ^addr_i[ADDR_WIDTH-1:OFF+IW];
`endif
    logic unused_lo;
    assign unused_lo = ^addr_i[OFF-1:0];

    // A pop frees a slot in the same cycle, so a full responder may still grant.
    assign pop   = rvalid_o & rready_i;
    assign gnt_o = rst_ni & req_i
                 & ((credits_q < CW'(MAX_OUTSTANDING)) | pop);
    assign grant = gnt_o;

    // Read happens before the write on the same edge; writes respond with zero.
    assign rd_word = (we_i || oor) ? '0 : mem_q[idx];

`ifdef OBI_SRAM_RESPONDER_ERR_EN
    assign in_entry = {oor, rd_word};
`else
    assign in_entry = rd_word;
`endif

    // SRAM byte-enabled write port; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (grant && we_i && !oor) begin
            for (int k = 0; k < NB; k++) begin
                if (be_i[k]) mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
            end
        end
    end

    // The queue register itself is the last latency stage, so the line has LATENCY-1 regs.
    generate
        if (LATENCY == 1) begin : g_nodly
            assign push       = grant;
            assign push_entry = in_entry;
        end else begin : g_dly
            logic [LATENCY-2:0] vld_q;
            logic [EW-1:0]      dat_q [LATENCY-1];

            // Shift granted entries toward the response queue.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    vld_q <= '0;
                    for (int i = 0; i < LATENCY - 1; i++) dat_q[i] <= '0;
                end else begin
                    vld_q[0] <= grant;
                    dat_q[0] <= in_entry;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        dat_q[i] <= dat_q[i-1];
                    end
                end
            end

            assign push       = vld_q[LATENCY-2];
            assign push_entry = dat_q[LATENCY-2];
        end
    endgenerate

    // Response queue storage; occupancy is tracked separately so no reset needed.
    always_ff @(posedge clk_i) begin
        if (push) q_mem_q[wptr_q] <= push_entry;
    end

    // Next-state for queue pointers, occupancy and credits.
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        qcnt_d    = qcnt_q;
        credits_d = credits_q;
        if (push) begin
            wptr_d = (wptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = (rptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   qcnt_d = qcnt_q + 1'b1;
            2'b01:   qcnt_d = qcnt_q - 1'b1;
            default: qcnt_d = qcnt_q;
        endcase
        case ({grant, pop})
            2'b10:   credits_d = credits_q + 1'b1;
            2'b01:   credits_d = credits_q - 1'b1;
            default: credits_d = credits_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            qcnt_q    <= '0;
            credits_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            qcnt_q    <= qcnt_d;
            credits_q <= credits_d;
        end
    end

    assign head     = q_mem_q[rptr_q];
    assign rvalid_o = (qcnt_q != '0);
    assign rdata_o  = rvalid_o ? head[DATA_WIDTH-1:0] : '0;
`ifdef OBI_SRAM_RESPONDER_ERR_EN
    assign err_o    = rvalid_o & head[DATA_WIDTH];
`endif

endmodule
